// File: rtl/move_sequencer.sv
// Knight-move leg sequencer: turns in place to the commanded heading, ramps forward
// speed while counting line crossings, then ramps down and pulses cmd_done.
module move_sequencer #(
    parameter logic [9:0]  MAX_SPD    = 10'h2FF,
    parameter logic [9:0]  FRWRD_INC  = 10'd6,
    parameter logic [9:0]  FRWRD_DEC  = 10'd12,
    parameter logic [11:0] ERR_THRESH = 12'h02C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] cmd,
    input  logic        cmd_vld,
    output logic        cmd_rdy,
    input  logic [11:0] heading,
    input  logic        heading_rdy,
    input  logic        cntrIR,
    output logic        moving,
    output logic [9:0]  frwrd,
    output logic [11:0] error,
    output logic        err_vld,
    output logic        cmd_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TURN    = 2'd1,
        MOVE    = 2'd2,
        RAMP_DN = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [11:0] dsrd_hdng;
    logic [4:0]  sq_target;
    logic [4:0]  crossings;
    logic        cntr_ir_ff;

    logic        accept;
    logic        ir_rise;
    logic        last_cross;
    logic        turn_done;
    logic [11:0] err_mag;
    logic [10:0] frwrd_sum;
    logic [9:0]  frwrd_nxt;

    assign accept     = cmd_vld & cmd_rdy;
    assign ir_rise    = cntrIR & ~cntr_ir_ff;
    assign last_cross = ir_rise && ((crossings + 5'd1) == sq_target);
    assign turn_done  = heading_rdy && (err_mag < ERR_THRESH);
    assign frwrd_sum  = {1'b0, frwrd} + {1'b0, FRWRD_INC};

    // The most negative error has no positive twin in 12 bits, so it saturates.
    always_comb begin
        if (error == 12'h800) begin
            err_mag = 12'h7FF;
        end else if (error[11]) begin
            err_mag = -error;
        end else begin
            err_mag = error;
        end
    end

    // State register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)     next_state = TURN;
            TURN:    if (turn_done)  next_state = (sq_target == 5'd0) ? IDLE : MOVE;
            MOVE:    if (last_cross) next_state = RAMP_DN;
            RAMP_DN: if (frwrd == 10'd0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output / datapath decode
    always_comb begin
        cmd_rdy   = (state == IDLE);
        error     = heading - dsrd_hdng;
        err_vld   = heading_rdy;
        frwrd_nxt = frwrd;
        case (state)
            MOVE: begin
                if (heading_rdy) begin
                    frwrd_nxt = (frwrd_sum > {1'b0, MAX_SPD}) ? MAX_SPD : frwrd_sum[9:0];
                end
            end
            RAMP_DN: begin
                if (heading_rdy) begin
                    frwrd_nxt = (frwrd < FRWRD_DEC) ? 10'd0 : (frwrd - FRWRD_DEC);
                end
            end
            default: frwrd_nxt = 10'd0;
        endcase
    end

    // Registered outputs and leg context; cmd_done fires only on a real return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frwrd      <= 10'd0;
            moving     <= 1'b0;
            cmd_done   <= 1'b0;
            dsrd_hdng  <= 12'h000;
            sq_target  <= 5'd0;
            crossings  <= 5'd0;
            cntr_ir_ff <= 1'b0;
        end else begin
            frwrd      <= frwrd_nxt;
            moving     <= (next_state != IDLE);
            cmd_done   <= (state != IDLE) && (next_state == IDLE);
            cntr_ir_ff <= cntrIR;
            if (accept) begin
                dsrd_hdng <= (cmd[11:4] == 8'h00) ? 12'h000 : {cmd[11:4], 4'hF};
                sq_target <= {cmd[3:0], 1'b0};
                crossings <= 5'd0;
            end else if ((state == MOVE) && ir_rise) begin
                crossings <= crossings + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: directed vector table, hand-written leg sequences and
// randomized legs compared every cycle against a leg-level reference model.
module tb_move_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] cmd = 12'h000;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic [11:0] heading = 12'h000;
    logic        heading_rdy = 1'b0;
    logic        cntrIR = 1'b0;
    logic        moving;
    logic [9:0]  frwrd;
    logic [11:0] error;
    logic        err_vld;
    logic        cmd_done;

    always #5 clk = ~clk;

    move_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd),
        .cmd_vld     (cmd_vld),
        .cmd_rdy     (cmd_rdy),
        .heading     (heading),
        .heading_rdy (heading_rdy),
        .cntrIR      (cntrIR),
        .moving      (moving),
        .frwrd       (frwrd),
        .error       (error),
        .err_vld     (err_vld),
        .cmd_done    (cmd_done)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a leg is a phase plus a speed number and a crossing tally.
    localparam int P_IDLE = 0;
    localparam int P_TURN = 1;
    localparam int P_MOVE = 2;
    localparam int P_RAMP = 3;

    int m_phase, m_spd, m_dsrd, m_target, m_lines;
    bit m_ir_prev, m_done;

    task automatic model_reset();
        m_phase = P_IDLE; m_spd = 0; m_dsrd = 0; m_target = 0; m_lines = 0;
        m_ir_prev = 1'b0; m_done = 1'b0;
    endtask

    function automatic int err_of(input logic [11:0] h);
        return ((int'(h) - m_dsrd) % 4096 + 4096) % 4096;
    endfunction

    function automatic int mag_of(input logic [11:0] h);
        int e;
        e = err_of(h);
        if (e >= 2048) return (4096 - e > 2047) ? 2047 : 4096 - e;
        return e;
    endfunction

    task automatic model_update(input logic v, input logic [11:0] c, input logic [11:0] h,
                                input logic hr, input logic ir);
        bit rise;
        int mag;
        rise = ir && !m_ir_prev;
        mag = mag_of(h);
        m_ir_prev = ir;
        m_done = 1'b0;
        case (m_phase)
            P_IDLE: if (v) begin
                m_dsrd = (c[11:4] == 8'h00) ? 0 : int'(c[11:4]) * 16 + 15;
                m_target = 2 * int'(c[3:0]);
                m_lines = 0;
                m_phase = P_TURN;
            end
            P_TURN: if (hr && mag < 44) begin
                if (m_target == 0) begin m_phase = P_IDLE; m_done = 1'b1; end
                else m_phase = P_MOVE;
            end
            P_MOVE: begin
                if (hr) m_spd = (m_spd + 6 > 767) ? 767 : m_spd + 6;
                if (rise) begin
                    m_lines++;
                    if (m_lines == m_target) m_phase = P_RAMP;
                end
            end
            default: begin
                if (m_spd == 0) begin m_phase = P_IDLE; m_done = 1'b1; end
                else if (hr) m_spd = (m_spd < 12) ? 0 : m_spd - 12;
            end
        endcase
    endtask

    // Sampled outputs of the latest step
    logic        s_rdy, s_mov, s_done;
    logic [9:0]  s_frwrd;
    logic [11:0] s_err;

    // Entered and left at 1 time unit after a rising edge.
    task automatic step(input logic v, input logic [11:0] c, input logic [11:0] h,
                        input logic hr, input logic ir);
        logic [25:0] act_v, exp_v;
        cmd_vld = v; cmd = c; heading = h; heading_rdy = hr; cntrIR = ir;
        @(negedge clk);
        s_rdy = cmd_rdy; s_mov = moving; s_done = cmd_done; s_frwrd = frwrd; s_err = error;
        act_v = {cmd_rdy, moving, cmd_done, err_vld, frwrd, error};
        exp_v = {m_phase == P_IDLE, m_phase != P_IDLE, m_done, hr, 10'(m_spd), 12'(err_of(h))};
        check("cycle_vs_model", act_v, exp_v);
        @(posedge clk);
        model_update(v, c, h, hr, ir);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cmd_vld = 1'b0; heading_rdy = 1'b0; cntrIR = 1'b0;
        #1;
        check("rst_frwrd", frwrd, 0);
        check("rst_moving", moving, 0);
        check("rst_cmd_rdy", cmd_rdy, 1);
        check("rst_cmd_done", cmd_done, 0);
        check("rst_dsrd_hdng", error, heading);
        model_reset();
        @(posedge clk); #1;
        check("rst_hold_cmd_done", cmd_done, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        v;
        logic [11:0] c;
        logic [11:0] h;
        logic        hr;
        logic        rdy;
        logic        mov;
        logic        done;
        logic [9:0]  f;
        logic [11:0] e;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int last_nz, done_cnt, prev;
        bit seen_clamp, rdy_at_done, ever_nz;
        logic [3:0] ir_seq;
        logic       ir_lvl;

        vecs[0] = '{1'b1, 12'h3F2, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0,  12'h000};
        vecs[1] = '{1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0,  12'hC01};
        vecs[2] = '{1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0,  12'hC01};
        vecs[3] = '{1'b0, 12'h000, 12'h3F0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0,  12'hFF1};
        vecs[4] = '{1'b0, 12'h000, 12'h3F0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0,  12'hFF1};
        vecs[5] = '{1'b0, 12'h000, 12'h3F0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd6,  12'hFF1};
        vecs[6] = '{1'b0, 12'h000, 12'h3F0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd12, 12'hFF1};
        vecs[7] = '{1'b0, 12'h000, 12'h3F0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd12, 12'hFF1};
        vecs[8] = '{1'b1, 12'h000, 12'h3F0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd12, 12'hFF1};
        vecs[9] = '{1'b0, 12'h000, 12'h3F0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd18, 12'hFF1};

        #2;
        do_reset();

        // Turn then move; cmd_vld in MOVE must not disturb the desired heading.
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].v, vecs[i].c, vecs[i].h, vecs[i].hr, 1'b0);
            check($sformatf("vec%0d", i), {s_rdy, s_mov, s_done, s_frwrd, s_err},
                  {vecs[i].rdy, vecs[i].mov, vecs[i].done, vecs[i].f, vecs[i].e});
        end

        // Reset in the middle of MOVE at frwrd = 0x0C0.
        for (int i = 0; i < 28; i++) step(1'b0, 12'h000, 12'h3F0, 1'b1, 1'b0);
        check("pre_reset_frwrd", frwrd, 10'h0C0);
        do_reset();

        // Ramp saturation then a two-square... one-square leg to completion.
        step(1'b1, 12'h001, 12'h000, 1'b1, 1'b0);
        prev = 0; seen_clamp = 1'b0;
        for (int i = 0; i < 140; i++) begin
            step(1'b0, 12'h000, 12'h000, 1'b1, 1'b0);
            if (prev == 762 && s_frwrd == 10'h2FF) seen_clamp = 1'b1;
            prev = int'(s_frwrd);
        end
        check("sat_762_then_clamp", seen_clamp, 1'b1);
        check("sat_hold", frwrd, 10'h2FF);

        ir_seq = 4'b0111;
        last_nz = 0; done_cnt = 0; rdy_at_done = 1'b0;
        for (int i = 0; i < 88; i++) begin
            step(1'b0, 12'h000, 12'h000, 1'b1, (i < 8) ? ir_seq[(i % 4 == 3) ? 3 : 0] : 1'b0);
            if (s_frwrd != 10'd0) last_nz = int'(s_frwrd);
            if (s_done) begin done_cnt++; rdy_at_done = s_rdy; end
        end
        check("ramp_last_nonzero", last_nz, 11);
        check("ramp_done_pulses", done_cnt, 1);
        check("ramp_rdy_with_done", rdy_at_done, 1'b1);

        // Zero squares: turn exits on the first good heading_rdy.
        step(1'b1, 12'h000, 12'h010, 1'b1, 1'b0);
        ever_nz = 1'b0; done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 12'h000, 12'h010, 1'b1, 1'b0);
            if (s_frwrd != 10'd0) ever_nz = 1'b1;
            if (s_done) done_cnt++;
            if (i == 1) check("zero_sq_done_cycle", {s_done, s_rdy, s_mov}, 3'b110);
        end
        check("zero_sq_frwrd_zero", ever_nz, 1'b0);
        check("zero_sq_done_pulses", done_cnt, 1);

        // Threshold and 0x800 boundary during TURN (dsrd = 0x80F).
        step(1'b1, 12'h801, 12'h000, 1'b0, 1'b0);
        step(1'b0, 12'h000, 12'h00F, 1'b1, 1'b0);
        check("err_800", s_err, 12'h800);
        step(1'b0, 12'h000, 12'h83B, 1'b1, 1'b0);
        step(1'b0, 12'h000, 12'h7E3, 1'b1, 1'b0);
        step(1'b0, 12'h000, 12'h7E4, 1'b1, 1'b0);
        check("turn_held_at_thresh", s_frwrd, 10'd0);
        step(1'b0, 12'h000, 12'h7E4, 1'b1, 1'b0);
        step(1'b0, 12'h000, 12'h7E4, 1'b1, 1'b0);
        check("turn_exit_below_thresh", s_frwrd, 10'd6);
        do_reset();

        // Randomized legs against the model.
        ir_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic [11:0] h;
            int sel;
            if (i == 1500) do_reset();
            sel = $urandom_range(0, 9);
            if (sel < 6) h = 12'(m_dsrd + $urandom_range(0, 80) - 40);
            else if (sel == 6) h = 12'(m_dsrd + 2048);
            else h = 12'($urandom);
            if ($urandom_range(0, 3) == 0) ir_lvl = ~ir_lvl;
            step($urandom_range(0, 3) == 0, {8'($urandom), 4'($urandom_range(0, 3))}, h,
                 1'($urandom_range(0, 1)), ir_lvl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
